// File: rtl/interrupt_scheduler.sv
// interrupt_scheduler: periodic timer interrupt plus keystroke FIFO, both
// arbitrated onto the processor's INT_IRQ / INT_IACK / INT_IEND handshake.
// Build option: define INTC_MASK_EN to add the INT_MASK[1:0] source-mask input.
module interrupt_scheduler #(
  parameter int TIMER_DIV      = 833333,
  parameter int KEY_FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       KEY_VALID,
  input  logic [7:0] KEY_CODE,
  output logic [1:0] INT_IRQ,
  input  logic       INT_IACK,
  input  logic       INT_IEND,
  output logic [7:0] KBD_KEY,
  output logic       TIMER_OVERRUN,
  output logic       KBD_OVERFLOW
`ifdef INTC_MASK_EN
  ,
  input  logic [1:0] INT_MASK
`endif
);

  localparam int CW = $clog2(TIMER_DIV);
  localparam int AW = $clog2(KEY_FIFO_DEPTH);
  localparam logic [CW-1:0] RELOAD   = CW'(TIMER_DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(KEY_FIFO_DEPTH);

  localparam logic [1:0] VEC_TIMER = 2'b00;
  localparam logic [1:0] VEC_KBD   = 2'b01;
  localparam logic [1:0] VEC_NONE  = 2'b11;
  localparam logic SRC_TIMER = 1'b0;
  localparam logic SRC_KBD   = 1'b1;

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} stateT;

  stateT         stateReg, stateNext;
  logic          srcReg, srcNext;
  logic          lastServedReg, lastServedNext;
  logic [1:0]    irqReg, irqNext;

  logic [CW-1:0] timerCntReg;
  logic          timerPendingReg;
  logic          timerOverrunReg;

  logic [7:0]    fifoMem [KEY_FIFO_DEPTH];
  logic [AW-1:0] rdPtrReg, wrPtrReg;
  logic [AW:0]   countReg;
  logic [7:0]    kbdKeyReg;
  logic          kbdOverflowReg;

  logic timerTick, timerAck, kbdPop, fifoEmpty, fifoFull, fifoPush, fifoDrop;
  logic maskTimer, maskKbd, timerReq, kbdReq, pickSrc;

`ifdef INTC_MASK_EN
  assign maskTimer = INT_MASK[0];
  assign maskKbd   = INT_MASK[1];
`else
  assign maskTimer = 1'b0;
  assign maskKbd   = 1'b0;
`endif

  assign timerTick = ENABLE && (timerCntReg == '0);
  assign fifoEmpty = (countReg == '0);
  assign fifoFull  = (countReg == FULL_CNT);
  // A full FIFO still accepts a key when the head is popped in the same cycle.
  assign fifoPush  = KEY_VALID && (!fifoFull || kbdPop);
  assign fifoDrop  = KEY_VALID && fifoFull && !kbdPop;
  // Masks only gate selection in IDLE; pending state keeps accumulating.
  assign timerReq  = timerPendingReg && !maskTimer;
  assign kbdReq    = !fifoEmpty && !maskKbd;
  // With both sources requesting, the one not served last wins.
  assign pickSrc   = (timerReq && kbdReq) ? (lastServedReg == SRC_TIMER) : kbdReq;

  // Handshake state register and registered interrupt vector.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stateReg      <= IDLE;
      srcReg        <= SRC_TIMER;
      lastServedReg <= SRC_TIMER;
      irqReg        <= VEC_NONE;
    end else begin
      stateReg      <= stateNext;
      srcReg        <= srcNext;
      lastServedReg <= lastServedNext;
      irqReg        <= irqNext;
    end
  end

  // Next-state and handshake side effects; ENABLE low overrides everything.
  always_comb begin
    stateNext      = stateReg;
    srcNext        = srcReg;
    lastServedNext = lastServedReg;
    irqNext        = irqReg;
    timerAck       = 1'b0;
    kbdPop         = 1'b0;
    if (!ENABLE) begin
      stateNext = IDLE;
      irqNext   = VEC_NONE;
    end else begin
      case (stateReg)
        IDLE: begin
          irqNext = VEC_NONE;
          if (timerReq || kbdReq) begin
            stateNext = ASSERT;
            srcNext   = pickSrc;
            irqNext   = pickSrc ? VEC_KBD : VEC_TIMER;
          end
        end
        ASSERT: begin
          if (INT_IACK) begin
            stateNext = SERVICE;
            timerAck  = (srcReg == SRC_TIMER);
          end
        end
        SERVICE: begin
          if (INT_IEND) begin
            stateNext      = IDLE;
            irqNext        = VEC_NONE;
            lastServedNext = srcReg;
            kbdPop         = (srcReg == SRC_KBD);
          end
        end
        default: begin
          stateNext = IDLE;
          irqNext   = VEC_NONE;
        end
      endcase
    end
  end

  // Tick divider, pending flag and sticky overrun.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      timerCntReg     <= RELOAD;
      timerPendingReg <= 1'b0;
      timerOverrunReg <= 1'b0;
    end else if (!ENABLE) begin
      timerCntReg     <= RELOAD;
      timerPendingReg <= 1'b0;
    end else begin
      timerCntReg <= timerTick ? RELOAD : timerCntReg - 1'b1;
      // A tick landing on the acknowledge edge re-arms the pending flag.
      if (timerTick) begin
        timerPendingReg <= 1'b1;
      end else if (timerAck) begin
        timerPendingReg <= 1'b0;
      end
      if (timerTick && timerPendingReg && !timerAck) begin
        timerOverrunReg <= 1'b1;
      end
    end
  end

  // Keystroke storage; no reset so it maps onto plain RAM.
  always_ff @(posedge CLK) begin
    if (fifoPush) begin
      fifoMem[wrPtrReg] <= KEY_CODE;
    end
  end

  // FIFO pointers, occupancy, registered head read and sticky overflow.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdPtrReg       <= '0;
      wrPtrReg       <= '0;
      countReg       <= '0;
      kbdKeyReg      <= '0;
      kbdOverflowReg <= 1'b0;
    end else begin
      if (fifoPush) begin
        wrPtrReg <= wrPtrReg + 1'b1;
      end
      if (kbdPop) begin
        rdPtrReg <= rdPtrReg + 1'b1;
      end
      case ({fifoPush, kbdPop})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
      if (fifoDrop) begin
        kbdOverflowReg <= 1'b1;
      end
      if (!fifoEmpty) begin
        kbdKeyReg <= fifoMem[rdPtrReg];
      end
    end
  end

  assign INT_IRQ       = irqReg;
  assign KBD_KEY       = kbdKeyReg;
  assign TIMER_OVERRUN = timerOverrunReg;
  assign KBD_OVERFLOW  = kbdOverflowReg;

endmodule

// File: tb/tb_interrupt_scheduler.sv
// tb_interrupt_scheduler: directed scenarios for interrupt_scheduler with
// TIMER_DIV=8 and KEY_FIFO_DEPTH=4; edge numbers count enabled clock edges.
module tb_interrupt_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       keyValid = 1'b0;
  logic [7:0] keyCode = 8'h00;
  logic [1:0] intIrq;
  logic       intIack = 1'b0;
  logic       intIend = 1'b0;
  logic [7:0] kbdKey;
  logic       timerOverrun;
  logic       kbdOverflow;
`ifdef INTC_MASK_EN
  logic [1:0] intMask = 2'b00;
`endif

  int checks = 0;
  int failures = 0;
  int n = 0;

  interrupt_scheduler #(.TIMER_DIV(8), .KEY_FIFO_DEPTH(4)) dut (
    .CLK(clk),
    .RESET(reset),
    .ENABLE(enable),
    .KEY_VALID(keyValid),
    .KEY_CODE(keyCode),
    .INT_IRQ(intIrq),
    .INT_IACK(intIack),
    .INT_IEND(intIend),
    .KBD_KEY(kbdKey),
    .TIMER_OVERRUN(timerOverrun),
    .KBD_OVERFLOW(kbdOverflow)
`ifdef INTC_MASK_EN
    ,
    .INT_MASK(intMask)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic runTo(input int k);
    while (n < k) cyc();
  endtask

  task automatic ackAt(input int k);
    runTo(k - 1);
    intIack = 1'b1;
    cyc();
    intIack = 1'b0;
  endtask

  task automatic endAt(input int k);
    runTo(k - 1);
    intIend = 1'b1;
    cyc();
    intIend = 1'b0;
  endtask

  task automatic pushAt(input int k, input logic [7:0] code);
    runTo(k - 1);
    keyValid = 1'b1;
    keyCode  = code;
    cyc();
    keyValid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    repeat (3) cyc();
    checks++; if (intIrq !== 2'b11) begin failures++; $display("FAIL reset_irq got=%b exp=11", intIrq); end
    checks++; if (kbdKey !== 8'h00) begin failures++; $display("FAIL reset_key got=%h exp=00", kbdKey); end
    checks++; if (timerOverrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", timerOverrun); end
    checks++; if (kbdOverflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", kbdOverflow); end
    $display("test_reset done");
  endtask

  task automatic test_timer();
    reset = 1'b0;
    enable = 1'b1;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      checks++; if (intIrq !== 2'b11) begin failures++; $display("FAIL timer_pre edge=%0d got=%b exp=11", n, intIrq); end
    end
    cyc();
    checks++; if (intIrq !== 2'b00) begin failures++; $display("FAIL timer_first got=%b exp=00", intIrq); end
    ackAt(11);
    checks++; if (intIrq !== 2'b00) begin failures++; $display("FAIL timer_hold got=%b exp=00", intIrq); end
    endAt(16);
    checks++; if (intIrq !== 2'b11) begin failures++; $display("FAIL timer_iend got=%b exp=11", intIrq); end
    runTo(17);
    checks++; if (intIrq !== 2'b00) begin failures++; $display("FAIL timer_period got=%b exp=00", intIrq); end
    checks++; if (timerOverrun !== 1'b0) begin failures++; $display("FAIL timer_overrun got=%b exp=0", timerOverrun); end
    enable = 1'b0;
    cyc();
    checks++; if (intIrq !== 2'b11) begin failures++; $display("FAIL timer_disable got=%b exp=11", intIrq); end
    $display("test_timer done");
  endtask

  task automatic test_kbd_single();
    enable = 1'b1;
    n = 0;
    pushAt(1, 8'h77);
    checks++; if (intIrq !== 2'b11) begin failures++; $display("FAIL kbd_lat1 got=%b exp=11", intIrq); end
    runTo(2);
    checks++; if (intIrq !== 2'b01) begin failures++; $display("FAIL kbd_irq got=%b exp=01", intIrq); end
    checks++; if (kbdKey !== 8'h77) begin failures++; $display("FAIL kbd_key_assert got=%h exp=77", kbdKey); end
    ackAt(4);
    checks++; if (intIrq !== 2'b01) begin failures++; $display("FAIL kbd_irq_service got=%b exp=01", intIrq); end
    runTo(5);
    checks++; if (kbdKey !== 8'h77) begin failures++; $display("FAIL kbd_key_service got=%h exp=77", kbdKey); end
    endAt(6);
    checks++; if (intIrq !== 2'b11) begin failures++; $display("FAIL kbd_iend got=%b exp=11", intIrq); end
    runTo(7);
    checks++; if (intIrq !== 2'b11) begin failures++; $display("FAIL kbd_empty got=%b exp=11", intIrq); end
    enable = 1'b0;
    cyc();
    $display("test_kbd_single done");
  endtask

  task automatic test_overflow();
    logic [7:0] drainExp [5];
    drainExp[0] = 8'h61; drainExp[1] = 8'h62; drainExp[2] = 8'h63;
    drainExp[3] = 8'h64; drainExp[4] = 8'h66;
    for (int i = 0; i < 5; i++) begin
      keyValid = 1'b1;
      keyCode = 8'h61 + 8'(i);
      cyc();
      keyValid = 1'b0;
      if (i == 3) begin
        checks++; if (kbdOverflow !== 1'b0) begin failures++; $display("FAIL ovf_full got=%b exp=0", kbdOverflow); end
      end
    end
    checks++; if (kbdOverflow !== 1'b1) begin failures++; $display("FAIL ovf_drop got=%b exp=1", kbdOverflow); end
    checks++; if (kbdKey !== 8'h61) begin failures++; $display("FAIL ovf_head got=%h exp=61", kbdKey); end
    // One service per enable window; the first one pushes 0x66 into the full FIFO while popping.
    for (int k = 0; k < 5; k++) begin
      enable = 1'b1;
      cyc();
      checks++; if (intIrq !== 2'b01) begin failures++; $display("FAIL drain_irq idx=%0d got=%b exp=01", k, intIrq); end
      checks++; if (kbdKey !== drainExp[k]) begin failures++; $display("FAIL drain_key idx=%0d got=%h exp=%h", k, kbdKey, drainExp[k]); end
      intIack = 1'b1;
      cyc();
      intIack = 1'b0;
      intIend = 1'b1;
      if (k == 0) begin
        keyValid = 1'b1;
        keyCode = 8'h66;
      end
      cyc();
      intIend = 1'b0;
      keyValid = 1'b0;
      checks++; if (intIrq !== 2'b11) begin failures++; $display("FAIL drain_iend idx=%0d got=%b exp=11", k, intIrq); end
      enable = 1'b0;
      cyc();
    end
    checks++; if (kbdOverflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", kbdOverflow); end
    $display("test_overflow done");
  endtask

  task automatic test_alternate();
    enable = 1'b1;
    n = 0;
    runTo(9);
    checks++; if (intIrq !== 2'b00) begin failures++; $display("FAIL alt_timer1 got=%b exp=00", intIrq); end
    ackAt(10);
    pushAt(11, 8'hA1);
    pushAt(12, 8'hA2);
    runTo(16);
    checks++; if (intIrq !== 2'b00) begin failures++; $display("FAIL alt_hold got=%b exp=00", intIrq); end
    endAt(17);
    checks++; if (intIrq !== 2'b11) begin failures++; $display("FAIL alt_iend1 got=%b exp=11", intIrq); end
    runTo(18);
    checks++; if (intIrq !== 2'b01) begin failures++; $display("FAIL alt_kbd1 got=%b exp=01", intIrq); end
    checks++; if (kbdKey !== 8'hA1) begin failures++; $display("FAIL alt_key1 got=%h exp=a1", kbdKey); end
    ackAt(19);
    endAt(20);
    runTo(21);
    checks++; if (intIrq !== 2'b00) begin failures++; $display("FAIL alt_timer2 got=%b exp=00", intIrq); end
    ackAt(22);
    endAt(23);
    runTo(24);
    checks++; if (intIrq !== 2'b01) begin failures++; $display("FAIL alt_kbd2 got=%b exp=01", intIrq); end
    checks++; if (kbdKey !== 8'hA2) begin failures++; $display("FAIL alt_key2 got=%h exp=a2", kbdKey); end
    ackAt(25);
    endAt(26);
    runTo(27);
    checks++; if (intIrq !== 2'b00) begin failures++; $display("FAIL alt_timer3 got=%b exp=00", intIrq); end
    checks++; if (timerOverrun !== 1'b0) begin failures++; $display("FAIL alt_overrun got=%b exp=0", timerOverrun); end
    enable = 1'b0;
    cyc();
    $display("test_alternate done");
  endtask

  task automatic test_enable_drop();
    enable = 1'b1;
    n = 0;
    pushAt(1, 8'h5A);
    runTo(2);
    checks++; if (intIrq !== 2'b01) begin failures++; $display("FAIL drop_irq got=%b exp=01", intIrq); end
    ackAt(3);
    runTo(8);
    checks++; if (intIrq !== 2'b01) begin failures++; $display("FAIL drop_service got=%b exp=01", intIrq); end
    enable = 1'b0;
    cyc();
    checks++; if (intIrq !== 2'b11) begin failures++; $display("FAIL drop_idle got=%b exp=11", intIrq); end
    checks++; if (kbdKey !== 8'h5A) begin failures++; $display("FAIL drop_key got=%h exp=5a", kbdKey); end
    repeat (2) cyc();
    enable = 1'b1;
    n = 0;
    cyc();
    checks++; if (intIrq !== 2'b01) begin failures++; $display("FAIL drop_reissue got=%b exp=01", intIrq); end
    checks++; if (kbdKey !== 8'h5A) begin failures++; $display("FAIL drop_reissue_key got=%h exp=5a", kbdKey); end
    ackAt(2);
    endAt(3);
    checks++; if (intIrq !== 2'b11) begin failures++; $display("FAIL drop_iend got=%b exp=11", intIrq); end
    runTo(4);
    checks++; if (intIrq !== 2'b11) begin failures++; $display("FAIL drop_nopending got=%b exp=11", intIrq); end
    enable = 1'b0;
    cyc();
    $display("test_enable_drop done");
  endtask

  task automatic test_overrun();
    enable = 1'b1;
    n = 0;
    runTo(9);
    checks++; if (intIrq !== 2'b00) begin failures++; $display("FAIL ovr_irq got=%b exp=00", intIrq); end
    endAt(10);
    checks++; if (intIrq !== 2'b00) begin failures++; $display("FAIL iend_ignored got=%b exp=00", intIrq); end
    runTo(11);
    checks++; if (intIrq !== 2'b00) begin failures++; $display("FAIL iend_ignored2 got=%b exp=00", intIrq); end
    runTo(15);
    checks++; if (timerOverrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b exp=0", timerOverrun); end
    runTo(16);
    checks++; if (timerOverrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", timerOverrun); end
    checks++; if (intIrq !== 2'b00) begin failures++; $display("FAIL ovr_irq_hold got=%b exp=00", intIrq); end
    ackAt(17);
    endAt(18);
    checks++; if (intIrq !== 2'b11) begin failures++; $display("FAIL ovr_iend got=%b exp=11", intIrq); end
    runTo(19);
    checks++; if (intIrq !== 2'b11) begin failures++; $display("FAIL ovr_cleared got=%b exp=11", intIrq); end
    checks++; if (kbdOverflow !== 1'b1) begin failures++; $display("FAIL ovr_kbd_sticky got=%b exp=1", kbdOverflow); end
    enable = 1'b0;
    cyc();
    $display("test_overrun done");
  endtask

  initial begin
    test_reset();
    test_timer();
    test_kbd_single();
    test_overflow();
    test_alternate();
    test_enable_drop();
    test_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
